// File: rtl/alu_issue_station_pkg.sv
// rtl/alu_issue_station_pkg.sv - shared types and constants for the ALU issue station
package alu_issue_station_pkg;

  localparam int RS_SIZE   = 16;
  localparam int RS_IDX_W  = 4;
  localparam int ROB_IDX_W = 4;
  localparam int DATA_W    = 32;
  localparam int OPENUM_W  = 6;
  localparam int OPTYPE_W  = 4;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [ROB_IDX_W-1:0] rob_index_t;
  typedef logic [RS_IDX_W-1:0]  rs_index_t;
  typedef logic [OPENUM_W-1:0]  openum_t;
  typedef logic [OPTYPE_W-1:0]  optype_t;

  // Op class codes
  localparam optype_t OP_NONE   = 4'd0;
  localparam optype_t OP_ARITH  = 4'd1;
  localparam optype_t OP_ARITHI = 4'd2;
  localparam optype_t OP_BRANCH = 4'd3;
  localparam optype_t OP_JAL    = 4'd4;
  localparam optype_t OP_JALR   = 4'd5;

  // Op enum codes (subset used by this station's clients)
  localparam openum_t OPENUM_NOP  = 6'd0;
  localparam openum_t OPENUM_ADD  = 6'd1;
  localparam openum_t OPENUM_SUB  = 6'd2;
  localparam openum_t OPENUM_ADDI = 6'd3;
  localparam openum_t OPENUM_BEQ  = 6'd4;
  localparam openum_t OPENUM_JAL  = 6'd5;
  localparam openum_t OPENUM_JALR = 6'd6;

  typedef struct packed {
    openum_t    op;
    optype_t    op_type;
    data_t      vj;
    data_t      vk;
    logic       qj_busy;
    rob_index_t qj;
    logic       qk_busy;
    rob_index_t qk;
    rob_index_t rob;
    data_t      pc;
    data_t      imm;
  } rs_entry_t;

endpackage

// File: rtl/alu_issue_station_if.sv
// rtl/alu_issue_station_if.sv - dispatch, CDB snoop and ALU issue bus of the issue station
interface alu_issue_station_if;
  import alu_issue_station_pkg::*;

  // dispatch side
  logic       disp_valid;
  openum_t    disp_op;
  optype_t    disp_opType;
  data_t      disp_vj;
  data_t      disp_vk;
  logic       disp_qj_busy;
  logic       disp_qk_busy;
  rob_index_t disp_qj;
  rob_index_t disp_qk;
  rob_index_t disp_rob_index;
  data_t      disp_pc;
  data_t      disp_imm;
  logic       rs_full;

  // common data bus ports
  logic       cdb_alu_valid;
  rob_index_t cdb_alu_tag;
  data_t      cdb_alu_data;
  logic       cdb_lsb_valid;
  rob_index_t cdb_lsb_tag;
  data_t      cdb_lsb_data;

  // issue to ALU
  logic       rs_to_alu_ready;
  openum_t    rs_to_alu_op;
  optype_t    rs_to_alu_opType;
  data_t      rs_to_alu_rs1;
  data_t      rs_to_alu_rs2;
  rob_index_t rs_to_alu_rob_index;
  data_t      rs_to_alu_PC;
  data_t      rs_to_alu_imm;

  modport master (
    output disp_valid, disp_op, disp_opType, disp_vj, disp_vk, disp_qj_busy, disp_qk_busy,
           disp_qj, disp_qk, disp_rob_index, disp_pc, disp_imm,
           cdb_alu_valid, cdb_alu_tag, cdb_alu_data, cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_data,
    input  rs_full, rs_to_alu_ready, rs_to_alu_op, rs_to_alu_opType, rs_to_alu_rs1,
           rs_to_alu_rs2, rs_to_alu_rob_index, rs_to_alu_PC, rs_to_alu_imm
  );

  modport slave (
    input  disp_valid, disp_op, disp_opType, disp_vj, disp_vk, disp_qj_busy, disp_qk_busy,
           disp_qj, disp_qk, disp_rob_index, disp_pc, disp_imm,
           cdb_alu_valid, cdb_alu_tag, cdb_alu_data, cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_data,
    output rs_full, rs_to_alu_ready, rs_to_alu_op, rs_to_alu_opType, rs_to_alu_rs1,
           rs_to_alu_rs2, rs_to_alu_rob_index, rs_to_alu_PC, rs_to_alu_imm
  );
endinterface

// File: rtl/alu_issue_station_rs_prio_select.sv
// rtl/alu_issue_station_rs_prio_select.sv - lowest-set-bit priority picker
module alu_issue_station_rs_prio_select #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] i_vec,
  output logic         o_found,
  output logic [W-1:0] o_idx
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_found = 1'b1;
        o_idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_issue_station.sv
// rtl/alu_issue_station.sv - reservation station scheduling the shared ALU
module alu_issue_station
  import alu_issue_station_pkg::*;
(
  input logic           clk_in,
  input logic           rst_in,
  input logic           rdy_in,
  input logic           clr_in,
  alu_issue_station_if.slave bus
);

  logic [RS_SIZE-1:0] r_busy;
  rs_entry_t          r_ent [RS_SIZE];

  logic [RS_SIZE-1:0] w_ready;
  logic               w_free_found;
  rs_index_t          w_free_idx;
  logic               w_rdy_found;
  rs_index_t          w_rdy_idx;
  logic               w_full;
  rs_entry_t          w_new_ent;

  logic w_j_alu, w_j_lsb, w_k_alu, w_k_lsb;

  // Readiness is taken from registered state only, so a wakeup takes effect one edge later
  always_comb begin
    w_ready = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      w_ready[i] = r_busy[i] && !r_ent[i].qj_busy && !r_ent[i].qk_busy;
    end
  end

  assign w_full      = &r_busy;
  assign bus.rs_full = w_full;

  alu_issue_station_rs_prio_select #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_pick (
    .i_vec   (~r_busy),
    .o_found (w_free_found),
    .o_idx   (w_free_idx)
  );

  alu_issue_station_rs_prio_select #(.N(RS_SIZE), .W(RS_IDX_W)) u_ready_pick (
    .i_vec   (w_ready),
    .o_found (w_rdy_found),
    .o_idx   (w_rdy_idx)
  );

  assign w_j_alu = bus.disp_qj_busy && bus.cdb_alu_valid && (bus.cdb_alu_tag == bus.disp_qj);
  assign w_j_lsb = bus.disp_qj_busy && bus.cdb_lsb_valid && (bus.cdb_lsb_tag == bus.disp_qj);
  assign w_k_alu = bus.disp_qk_busy && bus.cdb_alu_valid && (bus.cdb_alu_tag == bus.disp_qk);
  assign w_k_lsb = bus.disp_qk_busy && bus.cdb_lsb_valid && (bus.cdb_lsb_tag == bus.disp_qk);

  // Build the incoming entry, capturing a same-cycle CDB broadcast (ALU port has priority)
  always_comb begin
    w_new_ent         = '0;
    w_new_ent.op      = bus.disp_op;
    w_new_ent.op_type = bus.disp_opType;
    w_new_ent.qj      = bus.disp_qj;
    w_new_ent.qk      = bus.disp_qk;
    w_new_ent.rob     = bus.disp_rob_index;
    w_new_ent.pc      = bus.disp_pc;
    w_new_ent.imm     = bus.disp_imm;
    w_new_ent.vj      = w_j_alu ? bus.cdb_alu_data : (w_j_lsb ? bus.cdb_lsb_data : bus.disp_vj);
    w_new_ent.vk      = w_k_alu ? bus.cdb_alu_data : (w_k_lsb ? bus.cdb_lsb_data : bus.disp_vk);
    w_new_ent.qj_busy = bus.disp_qj_busy && !w_j_alu && !w_j_lsb;
    w_new_ent.qk_busy = bus.disp_qk_busy && !w_k_alu && !w_k_lsb;
  end

  // Entry state, operand wakeup, dispatch write and registered issue to the ALU
  always_ff @(posedge clk_in) begin
    if (rst_in || clr_in) begin
      r_busy                  <= '0;
      bus.rs_to_alu_ready     <= FALSE;
      bus.rs_to_alu_op        <= '0;
      bus.rs_to_alu_opType    <= '0;
      bus.rs_to_alu_rs1       <= '0;
      bus.rs_to_alu_rs2       <= '0;
      bus.rs_to_alu_rob_index <= '0;
      bus.rs_to_alu_PC        <= '0;
      bus.rs_to_alu_imm       <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i] && r_ent[i].qj_busy) begin
          if (bus.cdb_alu_valid && bus.cdb_alu_tag == r_ent[i].qj) begin
            r_ent[i].vj      <= bus.cdb_alu_data;
            r_ent[i].qj_busy <= FALSE;
          end else if (bus.cdb_lsb_valid && bus.cdb_lsb_tag == r_ent[i].qj) begin
            r_ent[i].vj      <= bus.cdb_lsb_data;
            r_ent[i].qj_busy <= FALSE;
          end
        end
        if (r_busy[i] && r_ent[i].qk_busy) begin
          if (bus.cdb_alu_valid && bus.cdb_alu_tag == r_ent[i].qk) begin
            r_ent[i].vk      <= bus.cdb_alu_data;
            r_ent[i].qk_busy <= FALSE;
          end else if (bus.cdb_lsb_valid && bus.cdb_lsb_tag == r_ent[i].qk) begin
            r_ent[i].vk      <= bus.cdb_lsb_data;
            r_ent[i].qk_busy <= FALSE;
          end
        end
      end

      if (w_rdy_found) begin
        r_busy[w_rdy_idx]       <= FALSE;
        bus.rs_to_alu_ready     <= TRUE;
        bus.rs_to_alu_op        <= r_ent[w_rdy_idx].op;
        bus.rs_to_alu_opType    <= r_ent[w_rdy_idx].op_type;
        bus.rs_to_alu_rs1       <= r_ent[w_rdy_idx].vj;
        bus.rs_to_alu_rs2       <= r_ent[w_rdy_idx].vk;
        bus.rs_to_alu_rob_index <= r_ent[w_rdy_idx].rob;
        bus.rs_to_alu_PC        <= r_ent[w_rdy_idx].pc;
        bus.rs_to_alu_imm       <= r_ent[w_rdy_idx].imm;
      end else begin
        bus.rs_to_alu_ready <= FALSE;
      end

      // Free slot comes from registered busy, so it never collides with the issuing entry
      if (bus.disp_valid && w_free_found && !w_full) begin
        r_busy[w_free_idx] <= TRUE;
        r_ent[w_free_idx]  <= w_new_ent;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_station.sv
// tb/tb_alu_issue_station.sv - directed self-checking bench for alu_issue_station
module tb_alu_issue_station;
  import alu_issue_station_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in, clr_in;
  int   checks = 0;
  int   errors = 0;

  alu_issue_station_if bus ();

  alu_issue_station dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .clr_in (clr_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.disp_valid     = 1'b0;
    bus.disp_op        = '0;
    bus.disp_opType    = '0;
    bus.disp_vj        = '0;
    bus.disp_vk        = '0;
    bus.disp_qj_busy   = 1'b0;
    bus.disp_qk_busy   = 1'b0;
    bus.disp_qj        = '0;
    bus.disp_qk        = '0;
    bus.disp_rob_index = '0;
    bus.disp_pc        = '0;
    bus.disp_imm       = '0;
    bus.cdb_alu_valid  = 1'b0;
    bus.cdb_alu_tag    = '0;
    bus.cdb_alu_data   = '0;
    bus.cdb_lsb_valid  = 1'b0;
    bus.cdb_lsb_tag    = '0;
    bus.cdb_lsb_data   = '0;
  endtask

  task automatic disp(input openum_t op, input optype_t ty, input data_t vj, input data_t vk,
                      input logic qjb, input rob_index_t qj, input logic qkb, input rob_index_t qk,
                      input rob_index_t rob, input data_t pc, input data_t imm);
    bus.disp_valid     = 1'b1;
    bus.disp_op        = op;
    bus.disp_opType    = ty;
    bus.disp_vj        = vj;
    bus.disp_vk        = vk;
    bus.disp_qj_busy   = qjb;
    bus.disp_qj        = qj;
    bus.disp_qk_busy   = qkb;
    bus.disp_qk        = qk;
    bus.disp_rob_index = rob;
    bus.disp_pc        = pc;
    bus.disp_imm       = imm;
  endtask

  initial begin
    idle_inputs();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    clr_in = 1'b0;
    tick();
    rst_in = 1'b0;
    chk("reset_ready", 32'(bus.rs_to_alu_ready), 32'd0);
    chk("reset_rs1", bus.rs_to_alu_rs1, 32'd0);
    chk("reset_rob", 32'(bus.rs_to_alu_rob_index), 32'd0);
    chk("reset_pc", bus.rs_to_alu_PC, 32'd0);
    chk("reset_full", 32'(bus.rs_full), 32'd0);

    // Ready ADD: issues two edges after dispatch, single pulse
    disp(OPENUM_ADD, OP_ARITH, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1, 32'h100, 32'd0);
    tick();
    idle_inputs();
    chk("add_not_yet", 32'(bus.rs_to_alu_ready), 32'd0);
    tick();
    chk("add_ready", 32'(bus.rs_to_alu_ready), 32'd1);
    chk("add_rs1", bus.rs_to_alu_rs1, 32'd3);
    chk("add_rs2", bus.rs_to_alu_rs2, 32'd4);
    chk("add_rob", 32'(bus.rs_to_alu_rob_index), 32'd1);
    chk("add_pc", bus.rs_to_alu_PC, 32'h100);
    chk("add_op", 32'(bus.rs_to_alu_op), 32'(OPENUM_ADD));
    tick();
    chk("add_one_pulse", 32'(bus.rs_to_alu_ready), 32'd0);
    chk("add_rs1_hold", bus.rs_to_alu_rs1, 32'd3);

    // Wakeup from LSB port
    disp(OPENUM_ADDI, OP_ARITHI, 32'd0, 32'd0, 1'b1, 4'd5, 1'b0, 4'd0, 4'd2, 32'h104, 32'd8);
    tick();
    idle_inputs();
    tick();
    chk("wake_pending", 32'(bus.rs_to_alu_ready), 32'd0);
    bus.cdb_lsb_valid = 1'b1;
    bus.cdb_lsb_tag   = 4'd5;
    bus.cdb_lsb_data  = 32'h10;
    tick();
    idle_inputs();
    chk("wake_edge", 32'(bus.rs_to_alu_ready), 32'd0);
    tick();
    chk("wake_ready", 32'(bus.rs_to_alu_ready), 32'd1);
    chk("wake_rs1", bus.rs_to_alu_rs1, 32'h10);
    chk("wake_imm", bus.rs_to_alu_imm, 32'd8);
    chk("wake_optype", 32'(bus.rs_to_alu_opType), 32'(OP_ARITHI));

    // Same-cycle bypass, both ports matching: ALU wins
    disp(OPENUM_SUB, OP_ARITH, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd2, 4'd3, 32'h108, 32'd0);
    bus.cdb_alu_valid = 1'b1;
    bus.cdb_alu_tag   = 4'd2;
    bus.cdb_alu_data  = 32'd7;
    bus.cdb_lsb_valid = 1'b1;
    bus.cdb_lsb_tag   = 4'd2;
    bus.cdb_lsb_data  = 32'd9;
    tick();
    idle_inputs();
    tick();
    chk("bypass_ready", 32'(bus.rs_to_alu_ready), 32'd1);
    chk("bypass_rs2", bus.rs_to_alu_rs2, 32'd7);
    chk("bypass_rs1", bus.rs_to_alu_rs1, 32'd1);
    chk("bypass_rob", 32'(bus.rs_to_alu_rob_index), 32'd3);

    // qj and qk woken in the same cycle from different ports
    disp(OPENUM_ADD, OP_ARITH, 32'd0, 32'd0, 1'b1, 4'd6, 1'b1, 4'd7, 4'd4, 32'h10C, 32'd0);
    tick();
    idle_inputs();
    bus.cdb_alu_valid = 1'b1;
    bus.cdb_alu_tag   = 4'd6;
    bus.cdb_alu_data  = 32'hAA;
    bus.cdb_lsb_valid = 1'b1;
    bus.cdb_lsb_tag   = 4'd7;
    bus.cdb_lsb_data  = 32'hBB;
    tick();
    idle_inputs();
    chk("dual_wake_edge", 32'(bus.rs_to_alu_ready), 32'd0);
    tick();
    chk("dual_ready", 32'(bus.rs_to_alu_ready), 32'd1);
    chk("dual_rs1", bus.rs_to_alu_rs1, 32'hAA);
    chk("dual_rs2", bus.rs_to_alu_rs2, 32'hBB);

    // Ordering: three entries woken together issue lowest-index first
    for (int i = 0; i < 3; i++) begin
      disp(OPENUM_ADD, OP_ARITH, 32'd0, 32'(i + 1), 1'b1, 4'd8, 1'b0, 4'd0, 4'(5 + i), 32'h200, 32'd0);
      tick();
    end
    idle_inputs();
    bus.cdb_alu_valid = 1'b1;
    bus.cdb_alu_tag   = 4'd8;
    bus.cdb_alu_data  = 32'h20;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("order_ready", 32'(bus.rs_to_alu_ready), 32'd1);
      chk("order_rob", 32'(bus.rs_to_alu_rob_index), 32'(5 + i));
      chk("order_rs2", bus.rs_to_alu_rs2, 32'(i + 1));
    end
    tick();
    chk("order_done", 32'(bus.rs_to_alu_ready), 32'd0);

    // Full: 16 pending entries waiting on tag == index
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("not_full_at_15", 32'(bus.rs_full), 32'd0);
      disp(OPENUM_ADD, OP_ARITH, 32'd0, 32'd0, 1'b1, 4'(i), 1'b0, 4'd0, 4'(i), 32'h300, 32'd0);
      tick();
    end
    idle_inputs();
    chk("full_set", 32'(bus.rs_full), 32'd1);
    disp(OPENUM_ADD, OP_ARITH, 32'hDEAD, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'hE, 32'h400, 32'd0);
    tick();
    idle_inputs();
    chk("full_hold", 32'(bus.rs_full), 32'd1);
    tick();
    chk("full_ignored", 32'(bus.rs_to_alu_ready), 32'd0);
    bus.cdb_lsb_valid = 1'b1;
    bus.cdb_lsb_tag   = 4'd9;
    bus.cdb_lsb_data  = 32'h99;
    tick();
    idle_inputs();
    chk("full_wake_edge", 32'(bus.rs_full), 32'd1);
    tick();
    chk("full_issue_ready", 32'(bus.rs_to_alu_ready), 32'd1);
    chk("full_issue_rob", 32'(bus.rs_to_alu_rob_index), 32'd9);
    chk("full_issue_rs1", bus.rs_to_alu_rs1, 32'h99);
    chk("full_cleared", 32'(bus.rs_full), 32'd0);
    disp(OPENUM_ADD, OP_ARITH, 32'h55, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'hA, 32'h500, 32'd0);
    tick();
    idle_inputs();
    chk("refill_full", 32'(bus.rs_full), 32'd1);
    chk("refill_no_issue", 32'(bus.rs_to_alu_ready), 32'd0);
    tick();
    chk("refill_ready", 32'(bus.rs_to_alu_ready), 32'd1);
    chk("refill_rs1", bus.rs_to_alu_rs1, 32'h55);
    chk("refill_rob", 32'(bus.rs_to_alu_rob_index), 32'hA);

    // Stall with a woken entry, then flush
    bus.cdb_alu_valid = 1'b1;
    bus.cdb_alu_tag   = 4'd3;
    bus.cdb_alu_data  = 32'h33;
    tick();
    idle_inputs();
    chk("stall_pre", 32'(bus.rs_to_alu_ready), 32'd0);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_no_issue", 32'(bus.rs_to_alu_ready), 32'd0);
      chk("stall_rs1_hold", bus.rs_to_alu_rs1, 32'h55);
    end
    clr_in = 1'b1;
    tick();
    clr_in = 1'b0;
    rdy_in = 1'b1;
    chk("clr_ready", 32'(bus.rs_to_alu_ready), 32'd0);
    chk("clr_rs1", bus.rs_to_alu_rs1, 32'd0);
    chk("clr_full", 32'(bus.rs_full), 32'd0);
    bus.cdb_alu_valid = 1'b1;
    bus.cdb_alu_tag   = 4'd5;
    bus.cdb_alu_data  = 32'h66;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("clr_dropped", 32'(bus.rs_to_alu_ready), 32'd0);
    end
    disp(OPENUM_JAL, OP_JAL, 32'h77, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'hC, 32'h600, 32'h40);
    tick();
    idle_inputs();
    tick();
    chk("post_clr_ready", 32'(bus.rs_to_alu_ready), 32'd1);
    chk("post_clr_rs1", bus.rs_to_alu_rs1, 32'h77);
    chk("post_clr_imm", bus.rs_to_alu_imm, 32'h40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
